// File: rtl/mem_arb_pkg.sv
// Shared constants for the fetch / load-store memory port arbiter.
package mem_arb_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned STRB = XLEN / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Bytes touched by an access of the given size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word accesses: strobes, store replication,
// load shift/mask and natural-alignment check.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [STRB-1:0] wstrb,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_align,
  output logic            misaligned
);
  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    wstrb       = '0;
    wdata_rep   = wdata;
    rdata_align = '0;
    misaligned  = 1'b0;
    case (size)
      SZ_B: begin
        wstrb       = 4'b0001 << addr_lo;
        wdata_rep   = {4{wdata[7:0]}};
        rdata_align = {24'd0, shifted[7:0]};
      end
      SZ_H: begin
        wstrb       = 4'b0011 << addr_lo;
        wdata_rep   = {2{wdata[15:0]}};
        rdata_align = {16'd0, shifted[15:0]};
        misaligned  = addr_lo[0];
      end
      SZ_W: begin
        wstrb       = 4'b1111;
        rdata_align = shifted;
        misaligned  = |addr_lo;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-addressed memory port between
// instruction fetch and the load/store unit; one access in flight at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1048576
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_rsp_valid,
  input  logic            if_rsp_ready,
  output logic [XLEN-1:0] if_rsp_data,
  output logic            if_rsp_err,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic            d_req_we,
  input  logic [1:0]      d_req_size,
  input  logic [XLEN-1:0] d_req_wdata,
  output logic            d_rsp_valid,
  input  logic            d_rsp_ready,
  output logic [XLEN-1:0] d_rsp_data,
  output logic            d_rsp_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [STRB-1:0] mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);
  logic [1:0]      state, state_next;
  logic            owner, owner_next;
  logic            last_grant, last_grant_next;
  logic [1:0]      req_lo, req_lo_next;
  logic [1:0]      req_size, req_size_next;
  logic            req_we, req_we_next;

  logic            mem_en_next, mem_we_next;
  logic [XLEN-1:0] mem_addr_next, mem_wdata_next;
  logic [STRB-1:0] mem_wstrb_next;
  logic            if_rsp_valid_next, if_rsp_err_next;
  logic            d_rsp_valid_next, d_rsp_err_next;
  logic [XLEN-1:0] if_rsp_data_next, d_rsp_data_next;

  logic            grant_d, grant_if, accept, illegal, range_err, rsp_done;
  logic [XLEN-1:0] in_addr, in_wdata;
  logic [1:0]      in_size;
  logic            in_we;
  logic [1:0]      al_addr_lo, al_size;
  logic [STRB-1:0] al_wstrb;
  logic [XLEN-1:0] al_wdata_rep, al_rdata;
  logic            al_misaligned;

  // Ties go to whichever requester did not win the previous accept.
  assign grant_d      = d_req_valid && (!if_req_valid || last_grant == OWN_IF);
  assign grant_if     = if_req_valid && !grant_d;
  assign if_req_ready = !reset && state == ST_IDLE && grant_if;
  assign d_req_ready  = !reset && state == ST_IDLE && grant_d;
  assign accept       = if_req_ready || d_req_ready;

  assign in_addr  = grant_d ? d_req_addr  : if_req_addr;
  assign in_we    = grant_d ? d_req_we    : 1'b0;
  assign in_size  = grant_d ? d_req_size  : SZ_W;
  assign in_wdata = grant_d ? d_req_wdata : '0;

  // The aligner sees the incoming request in IDLE and the latched one afterwards.
  assign al_addr_lo = (state == ST_IDLE) ? in_addr[1:0] : req_lo;
  assign al_size    = (state == ST_IDLE) ? in_size      : req_size;

  assign range_err = (33'(in_addr) + 33'(size_bytes(in_size))) > 33'(MEM_DEPTH);
  assign illegal   = al_misaligned || in_size == SZ_X || range_err;
  assign rsp_done  = (owner == OWN_D) ? d_rsp_ready : if_rsp_ready;

  mem_lane_align u_align (
    .addr_lo     (al_addr_lo),
    .size        (al_size),
    .wdata       (in_wdata),
    .rdata       (mem_rdata),
    .wstrb       (al_wstrb),
    .wdata_rep   (al_wdata_rep),
    .rdata_align (al_rdata),
    .misaligned  (al_misaligned)
  );

  always_comb begin
    state_next        = state;
    owner_next        = owner;
    last_grant_next   = last_grant;
    req_lo_next       = req_lo;
    req_size_next     = req_size;
    req_we_next       = req_we;
    mem_en_next       = 1'b0;
    mem_we_next       = 1'b0;
    mem_addr_next     = mem_addr;
    mem_wstrb_next    = '0;
    mem_wdata_next    = mem_wdata;
    if_rsp_valid_next = if_rsp_valid;
    if_rsp_err_next   = if_rsp_err;
    if_rsp_data_next  = if_rsp_data;
    d_rsp_valid_next  = d_rsp_valid;
    d_rsp_err_next    = d_rsp_err;
    d_rsp_data_next   = d_rsp_data;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          owner_next      = grant_d ? OWN_D : OWN_IF;
          last_grant_next = grant_d ? OWN_D : OWN_IF;
          req_lo_next     = in_addr[1:0];
          req_size_next   = in_size;
          req_we_next     = in_we;
          if (illegal) begin
            state_next = ST_RESP;
            if (grant_d) begin
              d_rsp_valid_next = 1'b1;
              d_rsp_err_next   = 1'b1;
              d_rsp_data_next  = '0;
            end else begin
              if_rsp_valid_next = 1'b1;
              if_rsp_err_next   = 1'b1;
              if_rsp_data_next  = '0;
            end
          end else begin
            state_next     = ST_ACCESS;
            mem_en_next    = 1'b1;
            mem_we_next    = in_we;
            mem_addr_next  = {in_addr[XLEN-1:2], 2'b00};
            mem_wstrb_next = al_wstrb;
            mem_wdata_next = al_wdata_rep;
          end
        end
      end
      ST_ACCESS: begin
        state_next = ST_RESP;
        if (owner == OWN_D) begin
          d_rsp_valid_next = 1'b1;
          d_rsp_err_next   = 1'b0;
          d_rsp_data_next  = req_we ? '0 : al_rdata;
        end else begin
          if_rsp_valid_next = 1'b1;
          if_rsp_err_next   = 1'b0;
          if_rsp_data_next  = al_rdata;
        end
      end
      ST_RESP: begin
        if (rsp_done) begin
          state_next        = ST_IDLE;
          if_rsp_valid_next = 1'b0;
          if_rsp_err_next   = 1'b0;
          if_rsp_data_next  = '0;
          d_rsp_valid_next  = 1'b0;
          d_rsp_err_next    = 1'b0;
          d_rsp_data_next   = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      owner        <= OWN_IF;
      last_grant   <= OWN_IF;
      req_lo       <= '0;
      req_size     <= SZ_W;
      req_we       <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wstrb    <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_err    <= 1'b0;
      d_rsp_data   <= '0;
    end else begin
      state        <= state_next;
      owner        <= owner_next;
      last_grant   <= last_grant_next;
      req_lo       <= req_lo_next;
      req_size     <= req_size_next;
      req_we       <= req_we_next;
      mem_en       <= mem_en_next;
      mem_we       <= mem_we_next;
      mem_addr     <= mem_addr_next;
      mem_wstrb    <= mem_wstrb_next;
      mem_wdata    <= mem_wdata_next;
      if_rsp_valid <= if_rsp_valid_next;
      if_rsp_err   <= if_rsp_err_next;
      if_rsp_data  <= if_rsp_data_next;
      d_rsp_valid  <= d_rsp_valid_next;
      d_rsp_err    <= d_rsp_err_next;
      d_rsp_data   <= d_rsp_data_next;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus random traffic checked
// against a byte-level transaction model of the memory and arbitration rules.
module tb_mem_port_arbiter;
  localparam int unsigned MEM_DEPTH = 1048576;

  logic        clock, reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mem_port_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_size(d_req_size), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .d_rsp_err(d_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory array behind the port; the low window and the top 256 bytes do not alias.
  logic [31:0] ram [0:1023];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else if (mem_en && mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_wstrb[i]) ram[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end
  assign mem_rdata = ram[mem_addr[11:2]];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  ref_mem [int unsigned];
  bit          model_last_d;
  bit          obs_win_d;
  bit          p_if, p_d, p_d_we;
  logic [31:0] p_if_addr, p_d_addr, p_d_wdata;
  logic [1:0]  p_d_size;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] sz);
    int unsigned nb;
    if (sz == 2'd3) return 1'b1;
    nb = 1 << sz;
    if (a % nb != 0) return 1'b1;
    return (longint'({32'd0, a}) + longint'(nb)) > longint'(MEM_DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr(input int nb);
    logic [31:0] a;
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 80)      a = 32'($urandom_range(0, 32'h2FF));
    else if (r < 92) a = 32'(MEM_DEPTH - $urandom_range(1, 256));
    else if (r < 97) a = 32'(MEM_DEPTH + $urandom_range(0, 8));
    else             a = $urandom;
    if ($urandom_range(0, 9) < 8) a = a & 32'(~(nb - 1));
    return a;
  endfunction

  task automatic apply_pins();
    if_req_valid = p_if;
    if_req_addr  = p_if_addr;
    d_req_valid  = p_d;
    d_req_addr   = p_d_addr;
    d_req_we     = p_d_we;
    d_req_size   = p_d_size;
    d_req_wdata  = p_d_wdata;
  endtask

  task automatic set_if(input logic [31:0] a);
    p_if = 1'b1; p_if_addr = a;
  endtask

  task automatic set_d(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    p_d = 1'b1; p_d_we = we; p_d_size = sz; p_d_addr = a; p_d_wdata = wd;
  endtask

  // Runs one accept-to-handshake transaction; entered and left just after a rising edge.
  task automatic serve(input int stall);
    bit          win_d, is_err, we;
    logic [31:0] a, wd, exp_rd, exp_wd;
    logic [1:0]  sz;
    logic [3:0]  exp_strb;
    int          nb, lo;
    apply_pins();
    @(negedge clock);
    win_d = p_d && (!p_if || !model_last_d);
    check_eq("if_req_ready", 32'(if_req_ready), 32'(!win_d));
    check_eq("d_req_ready", 32'(d_req_ready), 32'(win_d));
    obs_win_d = d_req_ready;
    if (win_d) begin
      a = p_d_addr; sz = p_d_size; we = p_d_we; wd = p_d_wdata; p_d = 1'b0;
    end else begin
      a = p_if_addr; sz = 2'd2; we = 1'b0; wd = '0; p_if = 1'b0;
    end
    is_err   = ref_err(a, sz);
    exp_rd   = '0;
    exp_strb = '0;
    exp_wd   = '0;
    if (!is_err) begin
      nb = 1 << sz;
      lo = int'(a % 4);
      for (int i = 0; i < 4; i++) begin
        exp_strb[i]      = (i >= lo) && (i < lo + nb);
        exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
      end
      for (int i = 0; i < nb; i++) begin
        if (we) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        else    exp_rd = exp_rd | (32'(ref_rd(a + 32'(i))) << (8 * i));
      end
    end
    model_last_d = win_d;
    @(posedge clock); #1;
    apply_pins();
    if (!is_err) begin
      @(negedge clock);
      check_eq("mem_en_access", 32'(mem_en), 32'd1);
      check_eq("mem_we", 32'(mem_we), 32'(we));
      check_eq("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      check_eq("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
      if (we) check_eq("mem_wdata", mem_wdata, exp_wd);
      check_eq("rsp_valid_in_access", 32'(if_rsp_valid | d_rsp_valid), 32'd0);
      check_eq("req_ready_in_access", 32'(if_req_ready | d_req_ready), 32'd0);
      @(posedge clock); #1;
    end
    for (int c = stall; c >= 0; c--) begin
      if (win_d) begin d_rsp_ready = (c == 0); if_rsp_ready = 1'($urandom); end
      else begin if_rsp_ready = (c == 0); d_rsp_ready = 1'($urandom); end
      @(negedge clock);
      if (win_d) begin
        check_eq("d_rsp_valid", 32'(d_rsp_valid), 32'd1);
        check_eq("d_rsp_err", 32'(d_rsp_err), 32'(is_err));
        check_eq("d_rsp_data", d_rsp_data, exp_rd);
        check_eq("if_rsp_valid_idle", 32'(if_rsp_valid), 32'd0);
      end else begin
        check_eq("if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        check_eq("if_rsp_err", 32'(if_rsp_err), 32'(is_err));
        check_eq("if_rsp_data", if_rsp_data, exp_rd);
        check_eq("d_rsp_valid_idle", 32'(d_rsp_valid), 32'd0);
      end
      check_eq("mem_en_resp", 32'(mem_en), 32'd0);
      check_eq("req_ready_in_resp", 32'(if_req_ready | d_req_ready), 32'd0);
      @(posedge clock); #1;
    end
    if_rsp_ready = 1'b0;
    d_rsp_ready  = 1'b0;
  endtask

  task automatic drain();
    while (p_if || p_d) serve(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    p_if = 1'b0; p_d = 1'b0; p_d_we = 1'b0; p_d_size = 2'd2;
    p_if_addr = '0; p_d_addr = '0; p_d_wdata = '0;
    model_last_d = 1'b0;
    if_rsp_ready = 1'b0; d_rsp_ready = 1'b0;
    reset = 1'b1;
    apply_pins();
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_if_req_ready", 32'(if_req_ready), 32'd0);
    check_eq("rst_d_req_ready", 32'(d_req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(if_rsp_valid | d_rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(if_rsp_err | d_rsp_err), 32'd0);
    check_eq("rst_if_rsp_data", if_rsp_data, 32'd0);
    check_eq("rst_d_rsp_data", d_rsp_data, 32'd0);
    check_eq("rst_mem_en_we", 32'({mem_en, mem_we}), 32'd0);
    check_eq("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    apply_pins();

    // Contended requests alternate starting with the data port.
    for (int t = 0; t < 4; t++) begin
      if (!p_if) set_if(32'(t * 16));
      if (!p_d)  set_d(1'b0, 2'd2, 32'(64 + t * 4), 32'd0);
      serve(0);
      check_eq("grant_order", 32'(obs_win_d), 32'(t % 2 == 0));
    end
    drain();

    set_d(1'b1, 2'd2, 32'h100, 32'hDEADBEEF); serve(0);
    set_if(32'h100); serve(0);
    set_d(1'b1, 2'd0, 32'h203, 32'h123456AB); serve(1);
    set_d(1'b0, 2'd0, 32'h203, 32'h0); serve(0);
    set_d(1'b1, 2'd1, 32'h206, 32'h0000C0DE); serve(2);
    set_d(1'b0, 2'd2, 32'h204, 32'h0); serve(0);

    // Illegal and boundary requests.
    set_d(1'b0, 2'd1, 32'h101, 32'h0); serve(0);
    set_if(32'(MEM_DEPTH - 2)); serve(0);
    set_d(1'b0, 2'd2, 32'(MEM_DEPTH), 32'h0); serve(1);
    set_d(1'b0, 2'd3, 32'h40, 32'h0); serve(0);
    set_d(1'b1, 2'd2, 32'hFFFF_FFFC, 32'h55AA55AA); serve(0);
    set_d(1'b1, 2'd2, 32'(MEM_DEPTH - 4), 32'hCAFEF00D); serve(0);
    set_if(32'(MEM_DEPTH - 4)); serve(0);
    set_d(1'b1, 2'd0, 32'(MEM_DEPTH - 1), 32'h77); serve(0);
    set_d(1'b0, 2'd1, 32'(MEM_DEPTH - 2), 32'h0); serve(0);
    set_d(1'b0, 2'd1, 32'(MEM_DEPTH - 1), 32'h0); serve(0);

    // Long response stall on the data port while fetch is waiting.
    if (model_last_d) begin set_if(32'h0); serve(0); end
    set_d(1'b0, 2'd2, 32'h100, 32'h0);
    set_if(32'h200);
    serve(5);
    drain();

    for (int n = 0; n < 200; n++) begin
      if (!p_if && $urandom_range(0, 1) == 1) set_if(rand_addr(4));
      if (!p_d && $urandom_range(0, 2) != 0) begin
        logic [1:0] sz;
        sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        set_d(1'($urandom), sz, rand_addr((sz == 2'd3) ? 4 : (1 << sz)), $urandom);
      end
      if (!p_if && !p_d) set_if(rand_addr(4));
      serve(int'($urandom_range(0, 3)));
    end
    drain();

    // Reset while the memory access is in progress.
    set_if(32'h10);
    apply_pins();
    @(negedge clock);
    check_eq("pre_rst_accept", 32'(if_req_ready), 32'd1);
    @(posedge clock); #1;
    check_eq("pre_rst_mem_en", 32'(mem_en), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("mid_rst_rsp_valid", 32'(if_rsp_valid | d_rsp_valid), 32'd0);
    check_eq("mid_rst_req_ready", 32'(if_req_ready), 32'd0);
    @(negedge clock);
    check_eq("mid_rst_mem_we_strb", 32'({mem_we, mem_wstrb}), 32'd0);
    check_eq("mid_rst_rsp_valid_hold", 32'(if_rsp_valid | d_rsp_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_last_d = 1'b0;
    ref_mem.delete();
    serve(0);
    set_d(1'b1, 2'd2, 32'h20, 32'h12345678); serve(0);
    set_if(32'h20); serve(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
